counter_flopen: RTL and testbench



---
 rtl/counter_flopen.sv | 46 ++++
 tb/tb_counter_flopen.sv | 98 +++++++++
 2 files changed

// File: rtl/counter_flopen.sv
// counter_flopen: up-counter with terminal-count flags plus enabled load register; define COUNTER_FLOPEN_SATURATE_EN to make the counter saturate.
module counter_flopen #(
  parameter int CNT_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int TC_SHORT = 7,
  parameter int TC_LONG = (1 << CNT_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CntEn,
  input  logic                  CntClr,
  output logic [CNT_WIDTH-1:0]  Count,
  output logic                  LastShort,
  output logic                  LastLong,
  input  logic                  LoadEn,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q
);
  localparam logic [CNT_WIDTH-1:0] tc_short = CNT_WIDTH'(TC_SHORT);
  localparam logic [CNT_WIDTH-1:0] tc_long = CNT_WIDTH'(TC_LONG);
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic [DATA_WIDTH-1:0] q_d, q_q;
  logic inc;
  always_comb begin
`ifdef COUNTER_FLOPEN_SATURATE_EN
    inc = CntEn && !(&cnt_q);
`else
    inc = CntEn;
`endif
    cnt_d = CntClr ? '0 : inc ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    q_d = LoadEn ? D : q_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      q_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      q_q <= q_d;
    end
  end
  assign Count = cnt_q;
  assign Q = q_q;
  assign LastShort = cnt_q == tc_short;
  assign LastLong = cnt_q == tc_long;
endmodule

// File: tb/tb_counter_flopen.sv
// tb_counter_flopen: randomized and directed stimulus scored against a queued reference model.
module tb_counter_flopen;
  localparam int CW = 5;
  localparam int DW = 8;
  localparam int TS = 7;
  localparam int TL = (1 << CW) - 1;
`ifdef COUNTER_FLOPEN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [DW-1:0] q;
    logic ls;
    logic ll;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic CntEn = 1'b0;
  logic CntClr = 1'b0;
  logic LoadEn = 1'b0;
  logic [DW-1:0] D = '0;
  logic [DW-1:0] Q;
  logic [CW-1:0] Count;
  logic LastShort, LastLong;
  exp_t sb[$];
  exp_t e;
  int m_cnt = 0;
  logic [DW-1:0] m_q = '0;
  int checks = 0;
  int fails = 0;
  logic [7:0] pat = 8'b10100101;
  always #5 clk = ~clk;
  counter_flopen #(.CNT_WIDTH(CW), .DATA_WIDTH(DW), .TC_SHORT(TS), .TC_LONG(TL)) dut (
    .clk(clk), .reset(reset), .CntEn(CntEn), .CntClr(CntClr), .Count(Count),
    .LastShort(LastShort), .LastLong(LastLong), .LoadEn(LoadEn), .D(D), .Q(Q)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask
  task automatic step(input logic r, input logic en, input logic clr, input logic ld, input logic [DW-1:0] d);
    @(negedge clk);
    reset = r;
    CntEn = en;
    CntClr = clr;
    LoadEn = ld;
    D = d;
    if (r) begin
      m_cnt = 0;
      m_q = '0;
    end else begin
      if (clr) m_cnt = 0;
      else if (en) m_cnt = SAT ? (m_cnt == TL ? TL : m_cnt + 1) : (m_cnt + 1) % (1 << CW);
      if (ld) m_q = d;
    end
    sb.push_back('{CW'(m_cnt), m_q, m_cnt == TS, m_cnt == TL});
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("count", 32'(Count), 32'(e.cnt));
      chk("q", 32'(Q), 32'(e.q));
      chk("last_short", 32'(LastShort), 32'(e.ls));
      chk("last_long", 32'(LastLong), 32'(e.ll));
    end
  end
  initial begin
    step(1, 1, 0, 1, 8'hFF);
    step(0, 0, 0, 0, 8'h00);
    repeat (7) step(0, 1, 0, 0, DW'($urandom));
    step(0, 1, 1, 0, 8'h00);
    repeat (31) step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    for (int i = 7; i >= 0; i--) step(0, 0, 0, 1, {m_q[DW-2:0], pat[i]});
    repeat (3) step(0, 0, 0, 0, DW'($urandom));
    step(0, 1, 1, 0, ~m_q);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 1, 0, 8'h00);
    step(1, 1, 0, 1, 8'hFF);
    for (int i = 0; i < 400; i++)
      step($urandom_range(31) == 0, $urandom_range(3) != 0, $urandom_range(15) == 0,
           $urandom_range(1) == 1, DW'($urandom));
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
